rr_op_arbiter: RTL

- Round-robin arbiter and sequencer that shares one async_operator-style functional unit among num_req requesters.
- Each requester uses the codebase req/ack handshake: level req, one-cycle ack pulse with data.
- The block picks a winner, forwards its operand to the shared unit, waits for the unit's ack, then returns the result to the winner.
- It sits between the dataflow graph's operator instances and a single physical arithmetic unit.

---
 rtl/rr_op_arbiter_pkg.sv | 16 +
 rtl/rr_op_arbiter_rr_pick.sv | 41 ++++
 rtl/rr_op_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rr_op_arbiter_pkg.sv
// Shared definitions for the round-robin operator arbiter: FSM encoding and
// the grant-index width helper.
package rr_op_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_op_arbiter_rr_pick.sv
// Combinational round-robin priority finder: first set bit of eligible_i
// searching upward from ptr_i+1 with wrap-around.
module rr_pick
    import rr_op_arbiter_pkg::*;
#(
    parameter int n    = 4,
    parameter int id_w = id_width(n)
) (
    input  logic [n-1:0]    eligible_i,
    input  logic [id_w-1:0] ptr_i,
    output logic [id_w-1:0] winner_o,
    output logic            any_valid_o
);

    logic [id_w-1:0] hi_idx;
    logic [id_w-1:0] lo_idx;
    logic            hi_any;
    logic            lo_any;

    // Descending scan: the last hit is the lowest index, both overall and above ptr.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                lo_any = 1'b1;
                lo_idx = i[id_w-1:0];
                if (i > int'(ptr_i)) begin
                    hi_any = 1'b1;
                    hi_idx = i[id_w-1:0];
                end
            end
        end
    end

    assign winner_o    = hi_any ? hi_idx : lo_idx;
    assign any_valid_o = lo_any;

endmodule

// File: rtl/rr_op_arbiter.sv
// Round-robin arbiter that time-shares one req/ack functional unit among
// num_req requesters, latching the winner's operand and returning the result.
module rr_op_arbiter
    import rr_op_arbiter_pkg::*;
#(
    parameter  int num_req        = 4,
    parameter  int data_width     = 32,
    parameter  int timeout_cycles = 0,
    localparam int ID_W           = id_width(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_in,
    input  logic [data_width*num_req-1:0] din,
    output logic [num_req-1:0]            ack_out,
    output logic [data_width-1:0]         dout,
    output logic                          unit_req,
    output logic [data_width-1:0]         unit_din,
    input  logic                          unit_ack,
    input  logic [data_width-1:0]         unit_dout,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          err
);

    localparam int              CNT_W   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam bit              TO_EN   = (timeout_cycles > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e              state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ureq_q, ureq_d;
    logic [data_width-1:0]   udin_q, udin_d;
    logic [data_width-1:0]   dout_q, dout_d;
    logic [num_req-1:0]      ack_q, ack_d;
    logic                    err_q, err_d;

    logic [num_req-1:0]      eligible;
    logic [ID_W-1:0]         win;
    logic                    any_valid;
    logic [data_width-1:0]   op_win;
    logic [num_req-1:0]      grant_hot;
    logic                    timeout_hit;

    assign eligible = req_in & ~ack_q;

    rr_pick #(
        .n    (num_req),
        .id_w (ID_W)
    ) u_pick (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .winner_o    (win),
        .any_valid_o (any_valid)
    );

    always_comb begin
        op_win    = '0;
        grant_hot = '0;
        for (int i = 0; i < num_req; i++) begin
            if (win == ID_W'(i)) begin
                op_win = din[i*data_width +: data_width];
            end
            grant_hot[i] = (grant_q == ID_W'(i));
        end
    end

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ureq_d  = ureq_q;
        udin_d  = udin_q;
        dout_d  = dout_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    udin_d  = op_win;
                    ureq_d  = 1'b1;
                    grant_d = win;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A completion on the timeout edge still counts as a normal result.
                if (unit_ack) begin
                    dout_d  = unit_dout;
                    ureq_d  = 1'b0;
                    ack_d   = grant_hot;
                    ptr_d   = grant_q;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    ureq_d  = 1'b0;
                    err_d   = 1'b1;
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                ack_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= ID_W'(num_req - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            ureq_q  <= 1'b0;
            udin_q  <= '0;
            dout_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ureq_q  <= ureq_d;
            udin_q  <= udin_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ack_out  = ack_q;
    assign dout     = dout_q;
    assign unit_req = ureq_q;
    assign unit_din = udin_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule
